// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status bundle of the program loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  restart;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;
  logic [15:0]           word_count;

  modport master (
    output in_data, in_valid, restart,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, load_done, load_error, word_count
  );

  modport slave (
    input  in_data, in_valid, restart,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, load_done, load_error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed instruction image (A5, LEN_HI, LEN_LO, payload, XOR checksum) into
// instruction memory one word at a time while holding the CPU.
//
// state      | meaning
// st_idle    | waiting for header 0xA5, other bytes discarded
// st_len_hi  | expecting upper length byte
// st_len_lo  | expecting lower length byte, range check
// st_data    | assembling payload bytes into a word
// st_write   | one-cycle memory write, input bubble
// st_check   | expecting checksum byte
// st_done    | image loaded, CPU released
// st_error   | frame rejected, CPU kept on hold
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 1024
) (
  input logic         clock,
  input logic         reset_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    st_idle, st_len_hi, st_len_lo, st_data, st_write, st_check, st_done, st_error
  } state_t;

  localparam logic [16:0] max_w = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [31:0] asm_word;
  logic [7:0]  chk;
  logic [1:0]  byte_idx;
  logic [15:0] word_count;

  logic        rdy;
  logic        take;
  logic        restart_ok;
  logic [15:0] n_in;

  assign rdy        = (state != st_write);
  assign take       = bus.in_valid && rdy;
  assign restart_ok = bus.restart && ((state == st_done) || (state == st_error));
  assign n_in       = {len_hi, bus.in_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= st_idle;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.imem_we    = 1'b0;
    bus.cpu_hold   = 1'b1;
    bus.load_done  = 1'b0;
    bus.load_error = 1'b0;
    unique case (state)
      st_idle: begin
        bus.cpu_hold = 1'b0;
        if (take && (bus.in_data == 8'hA5)) state_nxt = st_len_hi;
      end
      st_len_hi: if (take) state_nxt = st_len_lo;
      st_len_lo: begin
        if (take) begin
          if ({1'b0, n_in} > max_w) state_nxt = st_error;
          else if (n_in == 16'd0)   state_nxt = st_check;
          else                      state_nxt = st_data;
        end
      end
      st_data: if (take && (byte_idx == 2'd3)) state_nxt = st_write;
      st_write: begin
        bus.imem_we = 1'b1;
        state_nxt   = ((word_count + 16'd1) == len) ? st_check : st_data;
      end
      st_check: if (take) state_nxt = (bus.in_data == chk) ? st_done : st_error;
      st_done: begin
        bus.cpu_hold  = 1'b0;
        bus.load_done = 1'b1;
        if (restart_ok) state_nxt = st_idle;
      end
      st_error: begin
        bus.load_error = 1'b1;
        if (restart_ok) state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_hi     <= '0;
      len        <= '0;
      asm_word   <= '0;
      chk        <= '0;
      byte_idx   <= '0;
      word_count <= '0;
    end else begin
      unique case (state)
        st_idle: begin
          if (take && (bus.in_data == 8'hA5)) begin
            word_count <= '0;
            chk        <= '0;
            byte_idx   <= '0;
          end
        end
        st_len_hi: if (take) len_hi <= bus.in_data;
        st_len_lo: if (take) len <= n_in;
        st_data: begin
          if (take) begin
            asm_word <= {asm_word[23:0], bus.in_data};
            chk      <= chk ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        st_write: word_count <= word_count + 16'd1;
        default: ;
      endcase
    end
  end

  // Address wraps naturally in ADDR_WIDTH bits.
  assign bus.in_ready   = rdy;
  assign bus.imem_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_count);
  assign bus.imem_wdata = asm_word;
  assign bus.word_count = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame loader bench: frames built from the byte-format rules, memory writes,
// timing and status compared against an independent model of the load protocol.
module tb_imem_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       restart = 1'b0;
  logic       sel = 1'b0;

  imem_loader_if #(.ADDR_WIDTH(10)) ifc0 ();
  imem_loader_if #(.ADDR_WIDTH(10)) ifc1 ();

  assign ifc0.in_data  = in_data;
  assign ifc0.in_valid = in_valid && !sel;
  assign ifc0.restart  = restart && !sel;
  assign ifc1.in_data  = in_data;
  assign ifc1.in_valid = in_valid && sel;
  assign ifc1.restart  = restart && sel;

  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(ifc0));
  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(1022), .MAX_WORDS(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(ifc1));

  logic        o_ready, o_we, o_hold, o_done, o_err;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [15:0] o_wc;
  assign o_ready = sel ? ifc1.in_ready   : ifc0.in_ready;
  assign o_we    = sel ? ifc1.imem_we    : ifc0.imem_we;
  assign o_hold  = sel ? ifc1.cpu_hold   : ifc0.cpu_hold;
  assign o_done  = sel ? ifc1.load_done  : ifc0.load_done;
  assign o_err   = sel ? ifc1.load_error : ifc0.load_error;
  assign o_addr  = sel ? ifc1.imem_addr  : ifc0.imem_addr;
  assign o_wdata = sel ? ifc1.imem_wdata : ifc0.imem_wdata;
  assign o_wc    = sel ? ifc1.word_count : ifc0.word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation logs; acceptance is recorded as the index of the accepting edge.
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          acc_q[$];
  int          done_q[$];
  always @(negedge clock) begin
    if (o_we) begin
      wa_q.push_back(o_addr);
      wd_q.push_back(o_wdata);
      wc_q.push_back(cyc);
    end
    if (in_valid && o_ready) acc_q.push_back(cyc + 1);
    if (o_done) done_q.push_back(cyc);
  end

  logic [7:0]  fq[$];
  logic [31:0] wq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_logs();
    @(posedge clock); #1;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete(); done_q.delete();
  endtask

  // Build the frame bytes from wq; checksum is the XOR of every payload byte.
  task automatic make_frame(input bit force_chk, input logic [7:0] chk_val);
    logic [7:0]  c;
    logic [15:0] n;
    logic [31:0] w;
    c = 8'h00;
    n = 16'(wq.size());
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(n[15:8]);
    fq.push_back(n[7:0]);
    foreach (wq[i]) begin
      w = wq[i];
      for (int b = 3; b >= 0; b--) begin
        fq.push_back(w[8*b +: 8]);
        c = c ^ w[8*b +: 8];
      end
    end
    fq.push_back(force_chk ? chk_val : c);
  endtask

  function automatic logic [7:0] good_chk();
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    foreach (wq[i]) begin
      w = wq[i];
      c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rs);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      step(gap);
    end
    in_data = b;
    in_valid = 1'b1;
    restart = rs;
    t = 0;
    while (!o_ready && t < 10) begin
      step(1);
      restart = 1'b0;
      t++;
    end
    chk("ready_bounded", 32'(t < 10), 32'd1);
    step(1);
    restart = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid one cycle in three, 2: random gaps
  task automatic send_frame(input int mode, input int rs_at, input int nbytes);
    int gap;
    for (int i = 0; i < nbytes; i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
      send_byte(fq[i], gap, i == rs_at);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input int base, input bit ok);
    int n;
    n = wq.size();
    step(3);
    chk("nwrites", 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk("waddr", 32'(wa_q[i]), 32'((base + i) % 1024));
      chk("wdata", wd_q[i], wq[i]);
      if (acc_q.size() > 4 * i + 6)
        chk("wlatency", 32'(wc_q[i]), 32'(acc_q[4 * i + 6]));
    end
    chk("load_done", 32'(o_done), 32'(ok));
    chk("load_error", 32'(o_err), 32'(!ok));
    chk("cpu_hold", 32'(o_hold), 32'(!ok));
    chk("word_count", 32'(o_wc), 32'(n));
    if (ok) begin
      if (done_q.size() > 0 && acc_q.size() > 0)
        chk("done_latency", 32'(done_q[0]), 32'(acc_q[acc_q.size() - 1]));
      else
        chk("done_seen", 32'(done_q.size()), 32'd1);
    end else begin
      chk("no_done", 32'(done_q.size()), 32'd0);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(1);
    chk("rst_done_clr", 32'(o_done), 32'd0);
    chk("rst_err_clr", 32'(o_err), 32'd0);
    chk("rst_hold_clr", 32'(o_hold), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_we"}, 32'(o_we), 32'd0);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_wdata"}, o_wdata, 32'd0);
    chk({tag, "_hold"}, 32'(o_hold), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_wc"}, 32'(o_wc), 32'd0);
  endtask

  task automatic load_frame_a();
    wq.delete();
    wq.push_back(32'h24090088);
    wq.push_back(32'h240A00EF);
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(1);

    // Frame A streamed back-to-back; fifth byte is held across the first write bubble.
    clear_logs();
    load_frame_a();
    make_frame(1'b0, 8'h00);
    chk("frame_a_chk", 32'(fq[fq.size() - 1]), 32'h64);
    send_frame(0, -1, fq.size());
    expect_frame(0, 1'b1);

    // Restart together with a byte: restart wins, byte is not taken as a header.
    in_data = 8'hA5; in_valid = 1'b1; restart = 1'b1;
    step(1);
    in_valid = 1'b0; restart = 1'b0;
    step(1);
    chk("rs_byte_done", 32'(o_done), 32'd0);
    chk("rs_byte_hold", 32'(o_hold), 32'd0);

    // Bad checksum.
    clear_logs();
    make_frame(1'b1, 8'h00);
    send_frame(0, -1, fq.size());
    expect_frame(0, 1'b0);
    do_restart();

    // Garbage before the header is dropped, then an empty frame.
    clear_logs();
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    in_valid = 1'b0;
    step(1);
    chk("garbage_hold", 32'(o_hold), 32'd0);
    clear_logs();
    wq.delete();
    make_frame(1'b0, 8'h00);
    send_frame(0, -1, fq.size());
    expect_frame(0, 1'b1);
    do_restart();

    // Frame A with valid one cycle in three and an ignored mid-frame restart.
    clear_logs();
    load_frame_a();
    make_frame(1'b0, 8'h00);
    send_frame(1, 5, fq.size());
    expect_frame(0, 1'b1);
    do_restart();

    // Random frames, random gaps, occasional corrupted checksum.
    for (int f = 0; f < 8; f++) begin
      bit bad;
      int n;
      clear_logs();
      n = int'($urandom_range(1, 6));
      bad = ($urandom_range(0, 2) == 0);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      make_frame(bad, good_chk() ^ 8'($urandom_range(1, 255)));
      if (!bad) make_frame(1'b0, 8'h00);
      send_frame(2, -1, fq.size());
      expect_frame(0, !bad);
      do_restart();
    end

    // Reset after six payload bytes: first word kept, second never written.
    clear_logs();
    load_frame_a();
    make_frame(1'b0, 8'h00);
    send_frame(0, -1, 9);
    step(2);
    chk("midrst_nwr", 32'(wa_q.size()), 32'd1);
    if (wd_q.size() > 0) chk("midrst_w0", wd_q[0], 32'h24090088);
    chk("midrst_hold_pre", 32'(o_hold), 32'd1);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(2);
    chk("midrst_nwr_post", 32'(wa_q.size()), 32'd1);
    clear_logs();
    send_frame(0, -1, fq.size());
    expect_frame(0, 1'b1);
    do_restart();

    // MAX_WORDS=4 instance: N=5 rejected right after LEN_LO.
    sel = 1'b1;
    clear_logs();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    in_valid = 1'b0;
    chk("max_err_now", 32'(o_err), 32'd1);
    step(2);
    chk("max_err", 32'(o_err), 32'd1);
    chk("max_hold", 32'(o_hold), 32'd1);
    chk("max_nwr", 32'(wa_q.size()), 32'd0);
    do_restart();

    // N == MAX_WORDS accepted; addresses wrap from 1022 past the top of memory.
    clear_logs();
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    make_frame(1'b0, 8'h00);
    send_frame(2, -1, fq.size());
    expect_frame(1022, 1'b1);
    do_restart();
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
